// File: rtl/mult16u_share_sched_if.sv
// Requester-side handshake bundle for the shared-multiplier scheduler.
// The master modport is the requester side and the slave modport is the scheduler side.
interface mult16u_share_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic [NREQ*2*WIDTH-1:0] rsp_product;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product
  );
endinterface

// File: rtl/mult16u_share_sched.sv
// Round-robin scheduler that shares one registered unsigned multiplier among NREQ requesters.
// Optional feature macro MULT_SHARE_STATS_EN adds the stat_issue/stat_stall counters.
module mult16u_share_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mult16u_share_sched_if.slave   bus,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     mul_p,
  output logic                   busy
`ifdef MULT_SHARE_STATS_EN
  ,
  output logic [31:0]            stat_issue,
  output logic [31:0]            stat_stall
`endif
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]        ptr_q;
  logic [NREQ-1:0]         rsp_vld_q;
  logic [NREQ*2*WIDTH-1:0] rsp_prod_q;
  logic [MUL_LAT:1]        tag_vld_p;
  logic [PTR_W-1:0]        tag_idx_p [1:MUL_LAT];

  logic [NREQ-1:0]  slot_busy;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  done_oh;
  logic [NREQ-1:0]  gnt_oh;
  logic             gnt_vld;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] cand_idx;
  int               cand;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    slot_busy = rsp_vld_q;
    done_oh   = '0;
    for (int s = 1; s <= MUL_LAT; s++)
      if (tag_vld_p[s]) slot_busy[tag_idx_p[s]] = 1'b1;
    if (tag_vld_p[MUL_LAT]) done_oh[tag_idx_p[MUL_LAT]] = 1'b1;

    eligible = bus.req_valid & ~slot_busy & {NREQ{~rst}};

    // Search starts at the pointer and wraps, so the last winner has lowest priority.
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = PTR_W'(cand);
      if (!gnt_vld && eligible[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    gnt_oh          = '0;
    gnt_oh[gnt_idx] = gnt_vld;
  end

  assign bus.req_ready   = gnt_oh;
  assign bus.rsp_valid   = rsp_vld_q;
  assign bus.rsp_product = rsp_prod_q;
  assign mul_a = gnt_vld ? bus.req_a[gnt_idx*WIDTH +: WIDTH] : '0;
  assign mul_b = gnt_vld ? bus.req_b[gnt_idx*WIDTH +: WIDTH] : '0;
  assign busy  = (|tag_vld_p) | (|rsp_vld_q);

  // Stage boundary: issue -> tag pipe -> response registers (tag valid tracks mul_p latency)
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      tag_vld_p  <= '0;
      rsp_vld_q  <= '0;
      rsp_prod_q <= '0;
    end else begin
      if (gnt_vld) ptr_q <= next_ptr(gnt_idx);
      tag_vld_p[1] <= gnt_vld;
      for (int s = 2; s <= MUL_LAT; s++)
        tag_vld_p[s] <= tag_vld_p[s-1];
      rsp_vld_q <= (rsp_vld_q & ~bus.rsp_ready) | done_oh;
      if (tag_vld_p[MUL_LAT])
        rsp_prod_q[tag_idx_p[MUL_LAT]*2*WIDTH +: 2*WIDTH] <= mul_p;
    end
  end

  always_ff @(posedge clk) begin
    tag_idx_p[1] <= gnt_idx;
    for (int s = 2; s <= MUL_LAT; s++)
      tag_idx_p[s] <= tag_idx_p[s-1];
  end

`ifdef MULT_SHARE_STATS_EN
  logic [31:0] stat_issue_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (gnt_vld) stat_issue_q <= stat_issue_q + 32'd1;
      if ((|bus.req_valid) && !gnt_vld) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issue = stat_issue_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
